// File: rtl/cpu_test_pkg.sv
// Shared types and constants for the CPU test sequencer and its RAMs.
package cpu_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_LOAD,
    ST_DRAIN,
    ST_READ,
    ST_DONE
  } state_e;

  // Program stream control bytes.
  localparam logic [7:0] END_MARKER   = 8'hFF;
  localparam logic [7:0] START_MARKER = 8'hFE;

  // Default build of the sequencer.
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_PROG_DEPTH   = 256;
  localparam int DEF_LANES        = 4;
  localparam int DEF_ADDR_W       = 5;
  localparam int DEF_VREG_FIRST   = 8;
  localparam int DEF_VREG_COUNT   = 16;
  localparam int DEF_RST_CYCLES   = 1;
  localparam int DEF_DRAIN_CYCLES = 32;
  localparam int DEF_READ_LAT     = 1;

endpackage

// File: rtl/tseq_ram.sv
// Simple one-write/one-read synchronous RAM; read data is registered, so a
// write becomes visible to a read issued on the following cycle.
module tseq_ram
  import cpu_test_pkg::*;
#(
  parameter int W     = DEF_DATA_W,
  parameter int DEPTH = DEF_PROG_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Storage write and registered read (contents are intentionally not reset).
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_test_sequencer.sv
// Drives the CPU byte-serial instruction port from a program RAM, then reads
// back the vector register file lane by lane and checks it against a golden RAM.
// LANES is expected to be a power of two (lane/register split is a bit slice).
module cpu_test_sequencer #(
  parameter int DATA_W       = cpu_test_pkg::DEF_DATA_W,
  parameter int PROG_DEPTH   = cpu_test_pkg::DEF_PROG_DEPTH,
  parameter int LANES        = cpu_test_pkg::DEF_LANES,
  parameter int ADDR_W       = cpu_test_pkg::DEF_ADDR_W,
  parameter int VREG_FIRST   = cpu_test_pkg::DEF_VREG_FIRST,
  parameter int VREG_COUNT   = cpu_test_pkg::DEF_VREG_COUNT,
  parameter int RST_CYCLES   = cpu_test_pkg::DEF_RST_CYCLES,
  parameter int DRAIN_CYCLES = cpu_test_pkg::DEF_DRAIN_CYCLES,
  parameter int READ_LAT     = cpu_test_pkg::DEF_READ_LAT,
  parameter logic [DATA_W-1:0] END_MARKER = DATA_W'(cpu_test_pkg::END_MARKER)
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n,
  input  logic                                     start_i,
  input  logic                                     abort_on_err_i,
  input  logic                                     prog_we_i,
  input  logic [$clog2(PROG_DEPTH)-1:0]            prog_addr_i,
  input  logic [DATA_W-1:0]                        prog_data_i,
  input  logic                                     gold_we_i,
  input  logic [$clog2(VREG_COUNT*LANES)-1:0]      gold_addr_i,
  input  logic [DATA_W-1:0]                        gold_data_i,
  output logic [DATA_W-1:0]                        instr_o,
  output logic                                     dut_reset_o,
  output logic                                     data_or_reg_o,
  output logic [ADDR_W-1:0]                        address_o,
  output logic [$clog2(LANES)-1:0]                 vout_addr_o,
  input  logic [DATA_W-1:0]                        value_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     pass_o,
  output logic [$clog2(VREG_COUNT*LANES+1)-1:0]    err_cnt_o,
  output logic [$clog2(VREG_COUNT*LANES)-1:0]      first_err_idx_o,
  output logic [DATA_W-1:0]                        first_err_val_o
);
  import cpu_test_pkg::*;

  localparam int NPAT   = VREG_COUNT * LANES;
  localparam int PA_W   = $clog2(PROG_DEPTH);
  localparam int IDX_W  = $clog2(NPAT);
  localparam int CNT_W  = $clog2(NPAT + 1);
  localparam int LANE_W = $clog2(LANES);
  localparam logic [15:0]       RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [15:0]       DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
  localparam logic [PA_W-1:0]   PROG_LAST  = PA_W'(PROG_DEPTH - 1);
  localparam logic [IDX_W:0]    NPAT_V     = (IDX_W + 1)'(NPAT);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NPAT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(NPAT);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(VREG_FIRST);
  localparam logic [LANE_W-1:0] LANE_TOP   = LANE_W'(LANES - 1);

  state_e             state_q, state_d;
  logic [15:0]        tmr_q, tmr_d;
  logic [PA_W-1:0]    prog_idx_q, prog_idx_d;
  logic [IDX_W:0]     issue_q, issue_d;
  logic [DATA_W-1:0]  instr_q, instr_d;
  logic               dut_rst_q, dut_rst_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0]   ferr_idx_q, ferr_idx_d;
  logic [DATA_W-1:0]  ferr_val_q, ferr_val_d;

  // Compare pipeline: stage 0 is written at issue, the golden byte joins at
  // stage 1 (one RAM read cycle later), and stage READ_LAT meets value_i.
  logic               pv_q    [0:READ_LAT];
  logic               pv_d    [0:READ_LAT];
  logic [IDX_W-1:0]   pidx_q  [0:READ_LAT];
  logic [IDX_W-1:0]   pidx_d  [0:READ_LAT];
  logic [DATA_W-1:0]  pgold_q [1:READ_LAT];
  logic [DATA_W-1:0]  pgold_d [1:READ_LAT];

  logic [PA_W-1:0]    prog_raddr;
  logic [DATA_W-1:0]  prog_rdata, gold_rdata;
  logic               cmp_valid, mismatch, abort_now;
  logic [IDX_W-1:0]   cmp_idx;

  tseq_ram #(.W(DATA_W), .DEPTH(PROG_DEPTH), .AW(PA_W)) u_prog_ram (
    .clk_i(clk_i), .we_i(prog_we_i & ~busy_q), .waddr_i(prog_addr_i),
    .wdata_i(prog_data_i), .raddr_i(prog_raddr), .rdata_o(prog_rdata)
  );

  tseq_ram #(.W(DATA_W), .DEPTH(NPAT), .AW(IDX_W)) u_gold_ram (
    .clk_i(clk_i), .we_i(gold_we_i & ~busy_q), .waddr_i(gold_addr_i),
    .wdata_i(gold_data_i), .raddr_i(issue_q[IDX_W-1:0]), .rdata_o(gold_rdata)
  );

  assign cmp_valid = pv_q[READ_LAT];
  assign cmp_idx   = pidx_q[READ_LAT];
  assign mismatch  = (state_q == ST_READ) && cmp_valid && (value_i != pgold_q[READ_LAT]);
  assign abort_now = mismatch && abort_on_err_i;

  // Next-state and next-output logic for the whole run sequence.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    prog_idx_d = prog_idx_q;
    issue_d    = issue_q;
    instr_d    = '0;
    dut_rst_d  = dut_rst_q;
    addr_d     = addr_q;
    lane_d     = lane_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    ferr_idx_d = ferr_idx_q;
    ferr_val_d = ferr_val_q;
    prog_raddr = '0;
    pv_d[0]    = 1'b0;
    pidx_d[0]  = pidx_q[0];
    for (int s = 1; s <= READ_LAT; s++) begin
      pv_d[s]   = pv_q[s-1];
      pidx_d[s] = pidx_q[s-1];
    end
    pgold_d[1] = gold_rdata;
    for (int s = 2; s <= READ_LAT; s++) pgold_d[s] = pgold_q[s-1];

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d    = ST_RST;
          tmr_d      = '0;
          dut_rst_d  = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_cnt_d  = '0;
          ferr_idx_d = '0;
          ferr_val_d = '0;
          addr_d     = ADDR_FIRST;
          lane_d     = LANE_TOP;
        end
      end
      ST_RST: begin
        // On the last reset cycle byte 0 is already in the RAM output
        // register, so it is sent on the way out and byte 1 is fetched.
        if (tmr_q == RST_LAST) begin
          prog_raddr = PA_W'(1);
          dut_rst_d  = 1'b0;
          instr_d    = prog_rdata;
          tmr_d      = '0;
          prog_idx_d = PA_W'(1);
          state_d    = (prog_rdata == END_MARKER) ? ST_DRAIN : ST_LOAD;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_LOAD: begin
        prog_raddr = prog_idx_q + 1'b1;
        instr_d    = prog_rdata;
        if (prog_rdata == END_MARKER || prog_idx_q == PROG_LAST) begin
          state_d = ST_DRAIN;
          tmr_d   = '0;
        end else begin
          prog_idx_d = prog_idx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (tmr_q == DRAIN_LAST) begin
          state_d = ST_READ;
          issue_d = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_READ: begin
        if (issue_q < NPAT_V && !abort_now) begin
          addr_d    = ADDR_FIRST + ADDR_W'(issue_q[IDX_W-1:LANE_W]);
          lane_d    = LANE_TOP - issue_q[LANE_W-1:0];
          pv_d[0]   = 1'b1;
          pidx_d[0] = issue_q[IDX_W-1:0];
          issue_d   = issue_q + 1'b1;
        end
        if (mismatch) begin
          if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
          if (err_cnt_q == '0) begin
            ferr_idx_d = cmp_idx;
            ferr_val_d = value_i;
          end
        end
        if (abort_now || (cmp_valid && cmp_idx == IDX_LAST)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
          for (int s = 0; s <= READ_LAT; s++) pv_d[s] = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      prog_idx_q <= '0;
      issue_q    <= '0;
      instr_q    <= '0;
      dut_rst_q  <= 1'b0;
      addr_q     <= ADDR_FIRST;
      lane_q     <= LANE_TOP;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      ferr_idx_q <= '0;
      ferr_val_q <= '0;
      pv_q       <= '{default: 1'b0};
      pidx_q     <= '{default: '0};
      pgold_q    <= '{default: '0};
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      prog_idx_q <= prog_idx_d;
      issue_q    <= issue_d;
      instr_q    <= instr_d;
      dut_rst_q  <= dut_rst_d;
      addr_q     <= addr_d;
      lane_q     <= lane_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      ferr_idx_q <= ferr_idx_d;
      ferr_val_q <= ferr_val_d;
      pv_q       <= pv_d;
      pidx_q     <= pidx_d;
      pgold_q    <= pgold_d;
    end
  end

  assign instr_o         = instr_q;
  assign dut_reset_o     = dut_rst_q;
  assign data_or_reg_o   = 1'b1;
  assign address_o       = addr_q;
  assign vout_addr_o     = lane_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_idx_o = ferr_idx_q;
  assign first_err_val_o = ferr_val_q;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Directed bench for cpu_test_sequencer with a registered CPU readback model.
module tb_cpu_test_sequencer;
  localparam int NPAT = 64;

  logic       clk = 1'b0;
  logic       reset_n, start_i, abort_on_err_i;
  logic       prog_we_i, gold_we_i;
  logic [7:0] prog_addr_i, prog_data_i, gold_data_i;
  logic [5:0] gold_addr_i;
  logic [7:0] instr_o, value_i;
  logic       dut_reset_o, data_or_reg_o, busy_o, done_o, pass_o;
  logic [4:0] address_o;
  logic [1:0] vout_addr_o;
  logic [6:0] err_cnt_o;
  logic [5:0] first_err_idx_o;
  logic [7:0] first_err_val_o;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  int start_edge = 0;
  int nz_cnt = 0;
  int nz_base;
  int cyc;
  logic [7:0] last_nz = 8'h00;
  logic [7:0] dut_val [NPAT];

  always #5 clk = ~clk;

  cpu_test_sequencer #(.DRAIN_CYCLES(4)) dut (
    .clk_i(clk), .reset_n(reset_n), .start_i(start_i), .abort_on_err_i(abort_on_err_i),
    .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i), .prog_data_i(prog_data_i),
    .gold_we_i(gold_we_i), .gold_addr_i(gold_addr_i), .gold_data_i(gold_data_i),
    .instr_o(instr_o), .dut_reset_o(dut_reset_o), .data_or_reg_o(data_or_reg_o),
    .address_o(address_o), .vout_addr_o(vout_addr_o), .value_i(value_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
    .first_err_idx_o(first_err_idx_o), .first_err_val_o(first_err_val_o)
  );

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // CPU stand-in: register file lane value appears one cycle after address/lane.
  always @(posedge clk) begin
    int j;
    j = ((int'(address_o) - 8) * 4 + 3 - int'(vout_addr_o)) & 63;
    value_i <= dut_val[j];
  end

  // Count every nonzero instruction byte seen on the port.
  always @(negedge clk) begin
    if (instr_o != 8'h00) begin
      nz_cnt  <= nz_cnt + 1;
      last_nz <= instr_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_prog(input int a, input logic [7:0] d);
    prog_we_i = 1'b1; prog_addr_i = 8'(a); prog_data_i = d;
    tick();
    prog_we_i = 1'b0;
  endtask

  task automatic wr_gold(input int a, input logic [7:0] d);
    gold_we_i = 1'b1; gold_addr_i = 6'(a); gold_data_i = d;
    tick();
    gold_we_i = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    start_edge = edge_cnt;
  endtask

  // Cycles from the start_i cycle (counted as 1) to the first cycle with done_o.
  task automatic wait_done(output int cycles);
    int k;
    k = 0;
    while (done_o !== 1'b1 && k < 2000) begin
      tick();
      k++;
    end
    cycles = edge_cnt - start_edge + 1;
  endtask

  initial begin
    reset_n = 1'b0; start_i = 1'b0; abort_on_err_i = 1'b0;
    prog_we_i = 1'b0; prog_addr_i = '0; prog_data_i = '0;
    gold_we_i = 1'b0; gold_addr_i = '0; gold_data_i = '0;
    for (int j = 0; j < NPAT; j++) dut_val[j] = 8'(j * 3 + 7);
    repeat (3) tick();

    chk("rst_instr", 32'(instr_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_pass", 32'(pass_o), 32'h0);
    chk("rst_dutrst", 32'(dut_reset_o), 32'h0);
    chk("rst_addr", 32'(address_o), 32'd8);
    chk("rst_lane", 32'(vout_addr_o), 32'd3);
    chk("rst_dor", 32'(data_or_reg_o), 32'h1);
    chk("rst_err", 32'(err_cnt_o), 32'h0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 256; i++) wr_prog(i, 8'(i % 200 + 1));
    wr_prog(0, 8'h11); wr_prog(1, 8'h22); wr_prog(2, 8'h33); wr_prog(3, 8'hFF);
    for (int j = 0; j < NPAT; j++) wr_gold(j, dut_val[j]);

    // Run 1: short program, clean readback, READ address/lane sequence.
    nz_base = nz_cnt;
    do_start();
    chk("t1_dutrst_on", 32'(dut_reset_o), 32'h1);
    chk("t1_busy_on", 32'(busy_o), 32'h1);
    chk("t1_instr_rst", 32'(instr_o), 32'h0);
    tick();
    chk("t1_byte0", 32'(instr_o), 32'h11);
    chk("t1_dutrst_off", 32'(dut_reset_o), 32'h0);
    repeat (8) tick();
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("t4_addr_j%0d", j), 32'(address_o), 32'(8 + j / 4));
      chk($sformatf("t4_lane_j%0d", j), 32'(vout_addr_o), 32'(3 - j % 4));
      tick();
    end
    wait_done(cyc);
    chk("t1_cycles", 32'(cyc), 32'd75);
    chk("t1_pass", 32'(pass_o), 32'h1);
    chk("t1_err", 32'(err_cnt_o), 32'h0);
    chk("t1_busy_off", 32'(busy_o), 32'h0);
    chk("t1_nz_bytes", 32'(nz_cnt - nz_base), 32'd4);
    chk("t1_last_byte", 32'(last_nz), 32'hFF);
    repeat (3) tick();
    chk("t1_done_held", 32'(done_o), 32'h1);

    // Run 2: one corrupted golden entry, no abort.
    wr_gold(5, 8'h12);
    dut_val[5] = 8'h34;
    do_start();
    chk("t2_done_clr", 32'(done_o), 32'h0);
    wait_done(cyc);
    chk("t2_cycles", 32'(cyc), 32'd75);
    chk("t2_err", 32'(err_cnt_o), 32'h1);
    chk("t2_idx", 32'(first_err_idx_o), 32'd5);
    chk("t2_val", 32'(first_err_val_o), 32'h34);
    chk("t2_pass", 32'(pass_o), 32'h0);
    chk("t2_last_addr", 32'(address_o), 32'd23);
    chk("t2_last_lane", 32'(vout_addr_o), 32'd0);

    // Run 3: two corrupted entries, abort at the first.
    wr_gold(9, 8'h00);
    abort_on_err_i = 1'b1;
    do_start();
    wait_done(cyc);
    chk("t3_cycles", 32'(cyc), 32'd17);
    chk("t3_err", 32'(err_cnt_o), 32'h1);
    chk("t3_idx", 32'(first_err_idx_o), 32'd5);
    chk("t3_pass", 32'(pass_o), 32'h0);
    chk("t3_busy", 32'(busy_o), 32'h0);
    chk("t3_addr", 32'(address_o), 32'd9);
    chk("t3_lane", 32'(vout_addr_o), 32'd1);
    abort_on_err_i = 1'b0;
    dut_val[5] = 8'h16;
    wr_gold(5, 8'h16);
    wr_gold(9, 8'h22);

    // Run 5: reset in the 10th LOAD cycle, then a full-length restart.
    wr_prog(3, 8'h44);
    do_start();
    repeat (10) tick();
    chk("t5_byte9", 32'(instr_o), 32'h0A);
    reset_n = 1'b0;
    tick();
    chk("t5_instr", 32'(instr_o), 32'h0);
    chk("t5_busy", 32'(busy_o), 32'h0);
    chk("t5_dutrst", 32'(dut_reset_o), 32'h0);
    chk("t5_addr", 32'(address_o), 32'd8);
    reset_n = 1'b1;
    do_start();
    tick();
    chk("t5_restart_b0", 32'(instr_o), 32'h11);
    wait_done(cyc);
    chk("t5_full_cycles", 32'(cyc), 32'd327);
    chk("t5_pass", 32'(pass_o), 32'h1);

    // Run 6: start during DRAIN and program write during READ are ignored.
    wr_prog(3, 8'hFF);
    do_start();
    repeat (5) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (14) tick();
    prog_we_i = 1'b1; prog_addr_i = 8'h00; prog_data_i = 8'h99;
    tick();
    prog_we_i = 1'b0;
    wait_done(cyc);
    chk("t6_cycles", 32'(cyc), 32'd75);
    chk("t6_pass", 32'(pass_o), 32'h1);
    do_start();
    tick();
    chk("t6_ram_kept", 32'(instr_o), 32'h11);
    wait_done(cyc);
    chk("t6_cycles2", 32'(cyc), 32'd75);
    wr_prog(0, 8'h5A);
    do_start();
    tick();
    chk("t6_idle_write", 32'(instr_o), 32'h5A);
    wait_done(cyc);
    chk("t6_cycles3", 32'(cyc), 32'd75);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_test_sequencer.md
# cpu_test_sequencer

Synthesizable self-checking harness that drives the CPU's byte-serial instruction port and reads back its vector register file for comparison against a golden table. It replaces the fixed-timing testbench flow with a parametrised FSM: program and golden RAMs, DUT reset pulse, instruction streaming with end-marker detection, drain wait, pipelined lane-by-lane readback and error accounting. It sits beside `CPU` in FPGA/emulation tops and in the regression bench.

## Interface
- DATA_W, 8, instruction byte and vector lane width
- PROG_DEPTH, 256, program RAM entries
- LANES, 4, lanes per vector register (`vout_addr` range)
- ADDR_W, 5, DUT register address width
- VREG_FIRST, 8, first vector register checked
- VREG_COUNT, 16, registers checked; NPAT = VREG_COUNT*LANES
- RST_CYCLES, 1, DUT reset pulse length
- DRAIN_CYCLES, 32, wait between last byte and readback
- READ_LAT, 1, cycles from address/lane drive to valid `value_i`
- END_MARKER, 8'hFF, program terminator byte

Ports:
- clk_i  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start_i  in  1  run request (pulse)
- abort_on_err_i  in  1  stop readback at first mismatch
- prog_we_i / prog_addr_i / prog_data_i  in  1 / clog2(PROG_DEPTH) / DATA_W  program RAM write
- gold_we_i / gold_addr_i / gold_data_i  in  1 / clog2(NPAT) / DATA_W  golden RAM write
- instr_o  out  DATA_W  byte to DUT `instr_i`
- dut_reset_o  out  1  DUT reset (active-high)
- data_or_reg_o  out  1  DUT readback select, constant 1
- address_o  out  ADDR_W  DUT register address
- vout_addr_o  out  clog2(LANES)  DUT lane select
- value_i  in  DATA_W  DUT `value_o`
- busy_o, done_o, pass_o  out  1  status
- err_cnt_o  out  clog2(NPAT+1)  mismatch count
- first_err_idx_o  out  clog2(NPAT)  index of first mismatch
- first_err_val_o  out  DATA_W  DUT value at first mismatch

## Operation
- States: IDLE, RST, LOAD, DRAIN, READ, DONE.
- IDLE: `start_i`=1 -> RST; clears err_cnt, first_err_*, done_o, pass_o.
- RST: `dut_reset_o`=1 for RST_CYCLES, `instr_o`=0 -> LOAD.
- LOAD: one program byte per cycle from index 0. A byte equal to END_MARKER is still sent, then -> DRAIN. Otherwise -> DRAIN after index PROG_DEPTH-1. `instr_o`=0 in every other state.
- DRAIN: DRAIN_CYCLES cycles -> READ.
- READ: pattern j = 0..NPAT-1, one issued per cycle. `address_o` = VREG_FIRST + j/LANES, `vout_addr_o` = LANES-1 - (j mod LANES). Compare value_i against golden[j] READ_LAT cycles later via a pipeline of (j, golden) entries.
- Mismatch: err_cnt increments (saturates at NPAT). First mismatch latches idx and value. With `abort_on_err_i`=1, issue stops; in-flight compares are discarded; -> DONE.
- DONE: `done_o`=1, `pass_o` = (err_cnt==0), held until the next `start_i` (-> RST directly).
- `start_i` is ignored in RST..READ. RAM writes are ignored while `busy_o`=1.

## Timing
- Reset values: all outputs 0 except `address_o`=VREG_FIRST, `vout_addr_o`=LANES-1, `data_or_reg_o`=1. FSM -> IDLE. RAM contents are not reset.
- Reset mid-run aborts the run immediately. The next cycle shows the reset values.
- `busy_o`=1 from the cycle after `start_i` through the last READ compare.
- All outputs are registered. `instr_o` byte k appears at cycle RST_CYCLES+1+k after `start_i`.
- A full run with no marker or abort takes 1+RST_CYCLES+PROG_DEPTH+DRAIN_CYCLES+NPAT+READ_LAT cycles from `start_i` to `done_o`.
- RAM write-to-read: a write takes effect on the next cycle.

## Structure
- Package `cpu_test_pkg`: state enum, END_MARKER, START_MARKER (8'hFE), default parameter constants.
- Sub-module `tseq_ram`: simple 1W/1R synchronous RAM, instantiated twice (program and golden). The golden read latency is folded into the compare pipeline.

## Test plan
- Program 3 bytes + END_MARKER, DRAIN_CYCLES=4, DUT model echoes golden -> exactly 4 nonzero bytes on `instr_o`; `done_o`=1, `pass_o`=1, err_cnt=0.
- Golden[5] corrupted (0x12 vs DUT 0x34), abort=0 -> err_cnt=1, first_err_idx=5, first_err_val=0x34, pass=0, all 64 patterns issued.
- Golden[5] and [9] wrong, abort=1 -> err_cnt=1, DONE reached with no compare of j≥6 counted.
- READ sequencing check -> j=0..7 give address 8,8,8,8,9,9,9,9 and lane 3,2,1,0,3,2,1,0.
- `reset_n`=0 at the 10th LOAD cycle -> next cycle IDLE, `instr_o`=0, `busy_o`=0; `start_i` restarts from byte 0.
- `start_i` pulsed during DRAIN and prog_we during READ -> no effect; DONE timing unchanged and RAM unchanged.
